// File: rtl/mawg_audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mawg_audio_pkg
//  Brief    : Shared source codes, midscale constant, scheduler state type
//             and select canonicalisation helper for the audio select path.
//  Revision : 1.0 - initial release
// ============================================================================
package mawg_audio_pkg;

    localparam logic [1:0] SEL_MSG   = 2'b00;
    localparam logic [1:0] SEL_MOD   = 2'b01;
    localparam logic [1:0] SEL_DEMOD = 2'b10;

    localparam logic [7:0] MIDSCALE  = 8'h80;

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        FADE_OUT = 2'd1,
        SWITCH   = 2'd2,
        FADE_IN  = 2'd3
    } state_e;

    // Both 1x switch codes select the demodulated source.
    function automatic logic [1:0] canon_sel(input logic [1:0] raw);
        return raw[1] ? SEL_DEMOD : raw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sel_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : sel_debounce
//  Brief    : Accepts a canonical 2-bit select only after it has been held
//             unchanged long enough; the counter saturates once accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module sel_debounce
    import mawg_audio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_sel,
    output logic [1:0] o_req_sel
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [1:0]       req_q,  req_d;

    // Restart the stability count on any change; promote the candidate once it has held.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        req_d  = req_q;
        if (i_sel != cand_q) begin
            cand_d = i_sel;
            cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
            req_d  = cand_q;
        end else begin
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q <= SEL_MSG;
            cnt_q  <= '0;
            req_q  <= SEL_MSG;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            req_q  <= req_d;
        end
    end

    assign o_req_sel = req_q;

endmodule
`default_nettype wire

// File: rtl/audio_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : audio_select_ctrl
//  Brief    : Click-free audio source scheduler. Debounces the source switch,
//             fades the current source out, swaps at zero gain, fades back in,
//             and emits one registered offset-binary sample.
//  Revision : 1.0 - initial release
// ============================================================================
module audio_select_ctrl
    import mawg_audio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int STEP_DIV        = 4096,
    parameter int GAIN_W          = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel_req,
    input  logic [7:0] src_msg,
    input  logic [7:0] src_mod,
    input  logic [7:0] src_demod,
    output logic [7:0] to_audio,
    output logic [1:0] active_sel,
    output logic       busy
);

    localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [GAIN_W:0]   GMAX     = {1'b1, {GAIN_W{1'b0}}};
    localparam int                P_W      = 9 + GAIN_W + 1;

    logic [1:0]       req_sel;
    logic             tick;

    logic [PRE_W-1:0] pre_q,      pre_d;
    state_e           state_q,    state_d;
    logic [GAIN_W:0]  gain_q,     gain_d;
    logic [1:0]       active_q,   active_d;
    logic [7:0]       to_audio_q, to_audio_d;

    logic [7:0]             src_cur;
    logic signed [P_W-1:0]  d_ext;
    logic signed [P_W-1:0]  g_ext;
    logic signed [P_W-1:0]  prod;

    sel_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sel_debounce (
        .clk       (clk),
        .reset     (reset),
        .i_sel     (canon_sel(sel_req)),
        .o_req_sel (req_sel)
    );

    // Free-running gain-step prescaler; tick on the terminal count.
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    // Fade sequencer: transitions use the pre-step gain, the step is applied alongside.
    always_comb begin
        state_d  = state_q;
        gain_d   = gain_q;
        active_d = active_q;
        case (state_q)
            PLAY: begin
                gain_d = GMAX;
                if (req_sel != active_q) state_d = FADE_OUT;
            end
            FADE_OUT: begin
                if (tick && (gain_q != '0)) gain_d = gain_q - 1'b1;
                if (req_sel == active_q)    state_d = FADE_IN;
                else if (gain_q == '0)      state_d = SWITCH;
            end
            SWITCH: begin
                active_d = req_sel;
                gain_d   = '0;
                state_d  = FADE_IN;
            end
            FADE_IN: begin
                if (tick && (gain_q != GMAX)) gain_d = gain_q + 1'b1;
                if (req_sel != active_q)      state_d = FADE_OUT;
                else if (gain_q == GMAX)      state_d = PLAY;
            end
            default: begin
                state_d = PLAY;
                gain_d  = GMAX;
            end
        endcase
    end

    // Gain multiply: the offset-binary MSB flip yields the signed sample directly,
    // and adding midscale back is the same MSB flip on the floored result.
    always_comb begin
        case (active_q)
            SEL_MSG: src_cur = src_msg;
            SEL_MOD: src_cur = src_mod;
            default: src_cur = src_demod;
        endcase
        d_ext      = {{(P_W-7){~src_cur[7]}}, src_cur[6:0]};
        g_ext      = {{(P_W-GAIN_W-1){1'b0}}, gain_q};
        prod       = d_ext * g_ext;
        to_audio_d = MIDSCALE + 8'(prod >>> GAIN_W);
    end

    // State, gain, routing and output sample registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q      <= '0;
            state_q    <= PLAY;
            gain_q     <= GMAX;
            active_q   <= SEL_MSG;
            to_audio_q <= MIDSCALE;
        end else begin
            pre_q      <= pre_d;
            state_q    <= state_d;
            gain_q     <= gain_d;
            active_q   <= active_d;
            to_audio_q <= to_audio_d;
        end
    end

    assign to_audio   = to_audio_q;
    assign active_sel = active_q;
    assign busy       = (state_q != PLAY);

endmodule
`default_nettype wire

// File: tb/tb_audio_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_select_ctrl
//  Brief    : Self-checking bench for audio_select_ctrl with a behavioural
//             model, directed scenarios and randomized select/sample traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_audio_select_ctrl;

    localparam int DEB  = 4;
    localparam int SDIV = 2;
    localparam int GW   = 3;
    localparam int GMAX = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sel_req = 2'b00;
    logic [7:0] src_msg = 8'h00;
    logic [7:0] src_mod = 8'h00;
    logic [7:0] src_demod = 8'h00;
    wire  [7:0] to_audio;
    wire  [1:0] active_sel;
    wire        busy;

    always #5 clk = ~clk;

    audio_select_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .STEP_DIV        (SDIV),
        .GAIN_W          (GW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sel_req    (sel_req),
        .src_msg    (src_msg),
        .src_mod    (src_mod),
        .src_demod  (src_demod),
        .to_audio   (to_audio),
        .active_sel (active_sel),
        .busy       (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The switch is accepted once the last DEB+1 samples agree. The fade is
    // described as a direction (down/up), a playing flag and a one-cycle swap.
    int m_hist [DEB+1];
    int m_req, m_act, m_gain, m_phase, m_out;
    bit m_play, m_swap, m_down, m_valid;

    function automatic int src_of(int a);
        if (a == 0) return int'(src_msg);
        if (a == 1) return int'(src_mod);
        return int'(src_demod);
    endfunction

    function automatic int scale(int s, int g);
        int p, q;
        p = (s - 128) * g;
        q = p / GMAX;
        if (p < 0 && (p % GMAX) != 0) q = q - 1;
        return 128 + q;
    endfunction

    task automatic model_step();
        int  out_next, old_gain, new_gain, c;
        bit  tk, want, same;
        if (reset) begin
            foreach (m_hist[i]) m_hist[i] = 0;
            m_req = 0; m_act = 0; m_gain = GMAX; m_phase = 0; m_out = 128;
            m_play = 1; m_swap = 0; m_down = 0; m_valid = 1;
        end else if (m_valid) begin
            out_next = scale(src_of(m_act), m_gain);
            tk       = (m_phase == SDIV - 1);
            m_phase  = (m_phase + 1) % SDIV;
            want     = (m_req != m_act);
            old_gain = m_gain;
            if (m_swap) begin
                m_act  = m_req;
                m_swap = 0;
                m_down = 0;
            end else if (m_play) begin
                m_gain = GMAX;
                if (want) begin
                    m_play = 0;
                    m_down = 1;
                end
            end else begin
                new_gain = old_gain;
                if (tk) new_gain = m_down ? ((old_gain > 0) ? old_gain - 1 : 0)
                                          : ((old_gain < GMAX) ? old_gain + 1 : GMAX);
                if (m_down && want && old_gain == 0)          m_swap = 1;
                else if (!m_down && !want && old_gain == GMAX) m_play = 1;
                else                                           m_down = want;
                m_gain = new_gain;
            end
            c = (sel_req >= 2) ? 2 : int'(sel_req);
            for (int i = DEB; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = c;
            same = 1;
            for (int i = 1; i <= DEB; i++) if (m_hist[i] != m_hist[0]) same = 0;
            if (same) m_req = m_hist[0];
            m_out = out_next;
        end
    endtask

    always @(posedge clk) model_step();

    // Compare process: outputs are checked every cycle once the model has seen reset.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc to_audio",   to_audio,   m_out);
            check("cyc active_sel", active_sel, m_act);
            check("cyc busy",       busy,       !m_play);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_busy_cycle(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (busy) begin ok = 1; break; end
        end
        check({name, " busy rise"}, ok, 1);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(1);
            if (!busy) begin ok = 1; break; end
        end
        check({name, " busy fall"}, ok, 1);
    endtask

    initial begin
        bit ok, mono_bad, stay_bad;
        int prev, min_seen, hold;

        // 1. reset and first samples
        reset = 1; src_msg = 8'hC0; src_mod = 8'h00; src_demod = 8'h30;
        cyc(2);
        check("rst to_audio", to_audio, 8'h80);
        check("rst active", active_sel, 2'b00);
        check("rst busy", busy, 1'b0);
        reset = 0;
        cyc(1);
        check("first sample", to_audio, 8'hC0);

        // 2. glitch shorter than the debounce
        sel_req = 2'b01;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) sel_req = 2'b00;
            cyc(1);
            check("glitch busy", busy, 1'b0);
            check("glitch active", active_sel, 2'b00);
            check("glitch audio", to_audio, 8'hC0);
        end

        // 3. full swap message -> modulated
        src_msg = 8'hFF; src_mod = 8'h00;
        cyc(2);
        check("t3 full gain", to_audio, 8'hFF);
        sel_req = 2'b01;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (busy) begin ok = 1; break; end
        end
        check("t3 busy rise", ok, 1);
        prev = int'(to_audio); mono_bad = 0; ok = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (active_sel == 2'b01) begin ok = 1; break; end
            if (int'(to_audio) > prev) mono_bad = 1;
            prev = int'(to_audio);
        end
        check("t3 swap seen", ok, 1);
        check("t3 fade out monotonic", mono_bad, 0);
        check("t3 swap sample", to_audio, 8'h80);
        prev = int'(to_audio); mono_bad = 0; ok = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (int'(to_audio) > prev) mono_bad = 1;
            prev = int'(to_audio);
            if (!busy) begin ok = 1; break; end
        end
        check("t3 busy fall", ok, 1);
        check("t3 fade in monotonic", mono_bad, 0);
        check("t3 end sample", to_audio, 8'h00);
        check("t3 end active", active_sel, 2'b01);

        // 4. return to message, then a reversal mid-fade
        sel_req = 2'b00;
        wait_busy_cycle("t4 return");
        check("t4 return active", active_sel, 2'b00);
        check("t4 return sample", to_audio, 8'hFF);
        sel_req = 2'b01;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (to_audio == 8'hDF) begin ok = 1; break; end
        end
        check("t4 reach gain6", ok, 1);
        sel_req = 2'b00;
        min_seen = 255; stay_bad = 0; ok = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (active_sel != 2'b00) stay_bad = 1;
            if (int'(to_audio) < min_seen) min_seen = int'(to_audio);
            if (!busy) begin ok = 1; break; end
        end
        check("t4 busy fall", ok, 1);
        check("t4 no switch", stay_bad, 0);
        check("t4 min above mid", min_seen > 128, 1);
        check("t4 end sample", to_audio, 8'hFF);

        // 5. 10 and 11 are the same source
        src_demod = 8'h30;
        sel_req = 2'b10;
        wait_busy_cycle("t5 demod");
        check("t5 active", active_sel, 2'b10);
        check("t5 sample", to_audio, 8'h30);
        sel_req = 2'b11;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("t5 alias busy", busy, 1'b0);
            check("t5 alias active", active_sel, 2'b10);
        end

        // 6. reset during fade-in
        src_demod = 8'h80;
        sel_req = 2'b00;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (active_sel == 2'b00 && to_audio == 8'hAF) begin ok = 1; break; end
        end
        check("t6 reach gain3", ok, 1);
        reset = 1;
        cyc(1);
        check("t6 rst active", active_sel, 2'b00);
        check("t6 rst audio", to_audio, 8'h80);
        check("t6 rst busy", busy, 1'b0);
        reset = 0;
        cyc(1);
        check("t6 full gain", to_audio, 8'hFF);

        // 7. randomized traffic
        for (int it = 0; it < 400; it++) begin
            sel_req = 2'($urandom_range(0, 3));
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
            if ($urandom_range(0, 49) == 0) reset = 1;
            for (int k = 0; k < hold; k++) begin
                src_msg   = 8'($urandom);
                src_mod   = 8'($urandom);
                src_demod = 8'($urandom);
                cyc(1);
                reset = 0;
            end
        end
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
